// File: rtl/edge_event_scheduler_pkg.sv
// Shared types for the edge event scheduler: edge mode encoding and the
// offer state machine states.
package event_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_ANY  = 2'b11
   } edge_mode_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

endpackage

// File: rtl/edge_event_scheduler_if.sv
// Valid/ready event channel between the scheduler (master) and the
// downstream consumer (slave).
interface edge_event_scheduler_if #(
   parameter int N_CH = 4
);
   localparam int IDX_W = $clog2(N_CH);

   logic             ev_valid;
   logic             ev_ready;
   logic [IDX_W-1:0] ev_ch;
   logic             ev_rise;

   modport master (output ev_valid, output ev_ch, output ev_rise, input ev_ready);
   modport slave  (input ev_valid, input ev_ch, input ev_rise, output ev_ready);
endinterface

// File: rtl/edge_event_scheduler_rr_pick.sv
// Combinational round-robin finder: returns the first requesting index
// after 'last', wrapping around, so the most recent grant gets lowest priority.
module rr_pick #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan offsets from farthest to nearest so the nearest request after 'last' wins
   always_comb begin
      int w_cand;
      found  = 1'b0;
      idx    = '0;
      w_cand = 0;
      for (int k = N; k >= 1; k--) begin
         w_cand = (int'(last) + k) % N;
         if (req[w_cand]) begin
            found = 1'b1;
            idx   = IDX_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel edge event front end: per-channel edge detection into
// pending flags, served one at a time to a consumer with round-robin order.
module edge_event_scheduler
   import event_pkg::*;
#(
   parameter  int N_CH  = 4,
   localparam int IDX_W = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CH-1:0]     evt_in,
   input  logic [2*N_CH-1:0]   edge_mode,
   input  logic [N_CH-1:0]     pend_clr,
   input  logic                ovf_clr,
   edge_event_scheduler_if.master ev,
   output logic [N_CH-1:0]     pending,
   output logic [N_CH-1:0]     overflow
);

   logic [N_CH-1:0]  r_prev;
   logic             r_prime;
   logic [N_CH-1:0]  w_pending;
   logic [N_CH-1:0]  w_typ;
   logic [N_CH-1:0]  w_overflow;
   logic [IDX_W-1:0] r_lastGrant;
   logic [IDX_W-1:0] r_evCh;
   logic             r_evRise;
   state_t           r_state;
   state_t           w_nextState;
   logic             w_found;
   logic [IDX_W-1:0] w_pickIdx;
   logic             w_hs;

   // Previous-level history; the first cycle out of reset only primes it so
   // inputs already high at reset do not look like rising edges
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= '0;
         r_prime <= 1'b0;
      end else begin
         r_prev  <= evt_in;
         r_prime <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      edge_mode_t w_mode;
      logic       w_riseEdge;
      logic       w_fallEdge;
      logic       w_qual;
      logic       w_offered;
      logic       w_accept;
      logic       w_ovfSet;
      logic       r_pend;
      logic       r_typ;
      logic       r_ovf;

      assign w_mode     = edge_mode_t'(edge_mode[2*gi +: 2]);
      assign w_riseEdge = r_prime & evt_in[gi] & ~r_prev[gi];
      assign w_fallEdge = r_prime & ~evt_in[gi] & r_prev[gi];
      assign w_qual     = (w_riseEdge & ((w_mode == EDGE_RISE) | (w_mode == EDGE_ANY)))
                        | (w_fallEdge & ((w_mode == EDGE_FALL) | (w_mode == EDGE_ANY)));
      assign w_offered  = (r_state == S_OFFER) && (r_evCh == IDX_W'(gi));
      assign w_accept   = w_offered & ev.ev_ready;
      assign w_ovfSet   = w_qual & r_pend & ~w_accept;

      // Pending latch: a new edge beats both the handshake clear and pend_clr;
      // pend_clr cannot pull the flag out from under an active offer
      always_ff @(posedge clk) begin
         if (rst) begin
            r_pend <= 1'b0;
            r_typ  <= 1'b0;
            r_ovf  <= 1'b0;
         end else begin
            if (w_qual) begin
               r_pend <= 1'b1;
               r_typ  <= w_riseEdge;
            end else if (w_accept | (pend_clr[gi] & ~w_offered)) begin
               r_pend <= 1'b0;
            end
            if (w_ovfSet) begin
               r_ovf <= 1'b1;
            end else if (ovf_clr) begin
               r_ovf <= 1'b0;
            end
         end
      end

      assign w_pending[gi]  = r_pend;
      assign w_typ[gi]      = r_typ;
      assign w_overflow[gi] = r_ovf;
   end

   rr_pick #(.N(N_CH)) u_pick (
      .req   (w_pending),
      .last  (r_lastGrant),
      .found (w_found),
      .idx   (w_pickIdx)
   );

   // Offer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: pick when something is pending, leave only on handshake
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (w_found)     w_nextState = S_OFFER;
         S_OFFER: if (ev.ev_ready) w_nextState = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      ev.ev_valid = (r_state == S_OFFER);
      w_hs        = (r_state == S_OFFER) & ev.ev_ready;
   end

   // Offered channel and edge kind are captured at grant time and held for the whole offer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_evCh      <= '0;
         r_evRise    <= 1'b0;
         r_lastGrant <= IDX_W'(N_CH - 1);
      end else if ((r_state == S_IDLE) && w_found) begin
         r_evCh   <= w_pickIdx;
         r_evRise <= w_typ[w_pickIdx];
      end else if (w_hs) begin
         r_lastGrant <= r_evCh;
      end
   end

   assign ev.ev_ch   = r_evCh;
   assign ev.ev_rise = r_evRise;
   assign pending    = w_pending;
   assign overflow   = w_overflow;

endmodule
